// File: rtl/reg_writeback_if.sv
// Write-back request and register-file read-port bundle between the
// datapath control and the reg_writeback stage.
interface reg_writeback_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) ();
    logic              regWrite;
    logic              memToReg;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] memData;
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              wbPending;
    logic [DATA_W-1:0] wbData;

    modport master (
        output regWrite, memToReg, writeReg, aluResult, memData, readReg1, readReg2,
        input  readData1, readData2, wbPending, wbData
    );

    modport slave (
        input  regWrite, memToReg, writeReg, aluResult, memData, readReg1, readReg2,
        output readData1, readData2, wbPending, wbData
    );
endinterface

// File: rtl/reg_writeback.sv
// Write-back pipeline register plus 4-entry register file with r0 hardwired
// to zero and a bypass from the pending write onto both read ports.
module reg_writeback #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int ADDR_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_writeback_if.slave  wb
);

    function automatic logic [DATA_W-1:0] sel_wb_value(
        input logic              mem_to_reg,
        input logic [DATA_W-1:0] alu_value,
        input logic [DATA_W-1:0] mem_value
    );
        logic [DATA_W-1:0] result;
        if (mem_to_reg) begin
            result = mem_value;
        end else begin
            result = alu_value;
        end
        return result;
    endfunction

    // Priority: r0 reads zero, then the pending write, then the array.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] read_addr,
        input logic              pending,
        input logic [ADDR_W-1:0] pend_addr,
        input logic [DATA_W-1:0] pend_data,
        input logic [DATA_W-1:0] array_data
    );
        logic [DATA_W-1:0] result;
        if (read_addr == '0) begin
            result = '0;
        end else if (pending && (pend_addr == read_addr)) begin
            result = pend_data;
        end else begin
            result = array_data;
        end
        return result;
    endfunction

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wb_pending_q;
    logic              wb_pending_d;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [ADDR_W-1:0] wb_addr_d;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] wb_data_d;
    logic              capture_s;
    logic [DATA_W-1:0] read_data1_s;
    logic [DATA_W-1:0] read_data2_s;

    // Capture decision and next value of the write-back register.
    always_comb begin
        capture_s    = 1'b0;
        wb_pending_d = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        if (wb.regWrite && (wb.writeReg != '0)) begin
            capture_s    = 1'b1;
            wb_pending_d = 1'b1;
            wb_addr_d    = wb.writeReg;
            wb_data_d    = sel_wb_value(wb.memToReg, wb.aluResult, wb.memData);
        end else begin
            capture_s    = 1'b0;
            wb_pending_d = 1'b0;
        end
    end

    // Commit of the previously captured write into the array.
    always_comb begin
        regs_d = regs_q;
        if (wb_pending_q && (wb_addr_q != '0)) begin
            regs_d[wb_addr_q] = wb_data_q;
        end else begin
            regs_d = regs_q;
        end
    end

    // Write-back register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_pending_q <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
        end else begin
            wb_pending_q <= wb_pending_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
        end
    end

    // Register array; reset clears committed contents too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: only the read addresses are combinational inputs here.
    always_comb begin
        read_data1_s = read_port(wb.readReg1, wb_pending_q, wb_addr_q, wb_data_q,
                                 regs_q[wb.readReg1]);
        read_data2_s = read_port(wb.readReg2, wb_pending_q, wb_addr_q, wb_data_q,
                                 regs_q[wb.readReg2]);
    end

    assign wb.readData1 = read_data1_s;
    assign wb.readData2 = read_data2_s;
    assign wb.wbPending = wb_pending_q;
    assign wb.wbData    = wb_data_q;

    logic unused_s;
    assign unused_s = capture_s;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed, table-driven bench for reg_writeback: one vector per clock edge,
// plus hand-written reset and combinational-read sequences.
module tb_reg_writeback;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_writeback_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    reg_writeback #(.DATA_W(8), .NREG(4), .ADDR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic       m2r;
        logic [1:0] wr;
        logic [7:0] alu;
        logic [7:0] mem;
        logic [1:0] rr1;
        logic [1:0] rr2;
        logic       exp_pend;
        logic [7:0] exp_wbd;
        logic [7:0] exp_rd1;
        logic [7:0] exp_rd2;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [1:0] wr,
                         input logic [7:0] alu, input logic [7:0] mem,
                         input logic [1:0] rr1, input logic [1:0] rr2);
        bus.regWrite  = rw;
        bus.memToReg  = m2r;
        bus.writeReg  = wr;
        bus.aluResult = alu;
        bus.memData   = mem;
        bus.readReg1  = rr1;
        bus.readReg2  = rr2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b1, 1'b0, 2'd1, 8'hEE, 8'h00, 2'd1, 2'd2);

        // Held in reset across edges even with a write requested
        tick();
        tick();
        check("reset_pending", {7'd0, bus.wbPending}, 8'h00);
        check("reset_wbdata",  bus.wbData,  8'h00);
        check("reset_rd1",     bus.readData1, 8'h00);
        check("reset_rd2",     bus.readData2, 8'h00);
        drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 2'd0, 2'd0);
        rst_n = 1'b1;

        //          rw    m2r   wr    alu    mem    rr1   rr2   pend  wbd    rd1    rd2
        vecs[0] = '{1'b1, 1'b0, 2'd2, 8'h3C, 8'h00, 2'd2, 2'd0, 1'b1, 8'h3C, 8'h3C, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 2'd2, 8'h99, 8'h00, 2'd2, 2'd1, 1'b0, 8'h3C, 8'h3C, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 2'd3, 8'h11, 8'hA7, 2'd3, 2'd2, 1'b1, 8'hA7, 8'hA7, 8'h3C};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 2'd0, 2'd3, 1'b0, 8'hA7, 8'h00, 8'hA7};
        vecs[4] = '{1'b1, 1'b0, 2'd1, 8'h10, 8'h00, 2'd1, 2'd1, 1'b1, 8'h10, 8'h10, 8'h10};
        vecs[5] = '{1'b1, 1'b0, 2'd1, 8'h20, 8'h00, 2'd1, 2'd2, 1'b1, 8'h20, 8'h20, 8'h3C};
        vecs[6] = '{1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 2'd1, 2'd3, 1'b0, 8'h20, 8'h20, 8'hA7};
        vecs[7] = '{1'b1, 1'b0, 2'd1, 8'hC3, 8'h5A, 2'd1, 2'd0, 1'b1, 8'hC3, 8'hC3, 8'h00};
        vecs[8] = '{1'b1, 1'b1, 2'd3, 8'h00, 8'h81, 2'd1, 2'd3, 1'b1, 8'h81, 8'hC3, 8'h81};
        vecs[9] = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 2'd3, 2'd2, 1'b0, 8'h81, 8'h81, 8'h3C};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rw, vecs[i].m2r, vecs[i].wr, vecs[i].alu, vecs[i].mem,
                  vecs[i].rr1, vecs[i].rr2);
            tick();
            check($sformatf("v%0d_pending", i), {7'd0, bus.wbPending}, {7'd0, vecs[i].exp_pend});
            check($sformatf("v%0d_wbdata", i),  bus.wbData,    vecs[i].exp_wbd);
            check($sformatf("v%0d_rd1", i),     bus.readData1, vecs[i].exp_rd1);
            check($sformatf("v%0d_rd2", i),     bus.readData2, vecs[i].exp_rd2);
        end

        // Read ports follow readReg with no clock edge
        drive(1'b1, 1'b0, 2'd2, 8'h55, 8'h66, 2'd1, 2'd3);
        #1;
        check("comb_rd1_r1", bus.readData1, 8'hC3);
        check("comb_rd2_r3", bus.readData2, 8'h81);
        check("comb_no_wb_path", {7'd0, bus.wbPending}, 8'h00);

        // Reset after commit: r1=5A committed, then async reset between edges
        drive(1'b1, 1'b0, 2'd1, 8'h5A, 8'h00, 2'd1, 2'd2);
        tick();
        drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 2'd1, 2'd2);
        tick();
        check("pre_reset_r1", bus.readData1, 8'h5A);
        check("pre_reset_r2", bus.readData2, 8'h3C);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_rd1",     bus.readData1, 8'h00);
        check("async_reset_rd2",     bus.readData2, 8'h00);
        check("async_reset_pending", {7'd0, bus.wbPending}, 8'h00);
        check("async_reset_wbdata",  bus.wbData, 8'h00);
        rst_n = 1'b1;

        // First edge after release captures
        drive(1'b1, 1'b0, 2'd2, 8'h77, 8'h00, 2'd2, 2'd1);
        tick();
        check("mid_capture_pending", {7'd0, bus.wbPending}, 8'h01);
        check("mid_capture_rd1",     bus.readData1, 8'h77);
        check("mid_capture_rd2",     bus.readData2, 8'h00);
        drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 2'd2, 2'd1);
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("mid_reset_r2",      bus.readData1, 8'h00);
        check("mid_reset_pending", {7'd0, bus.wbPending}, 8'h00);
        check("mid_reset_wbdata",  bus.wbData, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage and register file for the 8-bit single-issue CPU datapath. Selects the write-back value (ALU result or memory read data), holds it for one cycle in a write-back pipeline register, and commits it to a 4-entry register file on the following edge. Serves the two read ports that feed the ALU operand multiplexers, with a bypass so a pending write is visible before it commits.

## Interface
- DATA_W, 8, datapath width
- NREG, 4, number of registers
- ADDR_W, 2, register address width (log2 NREG)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- regWrite  in  1  write-back request this cycle
- memToReg  in  1  0: write aluResult, 1: write memData
- writeReg  in  ADDR_W  destination register
- aluResult  in  DATA_W  ALU output
- memData  in  DATA_W  data memory read output
- readReg1  in  ADDR_W  read port 1 address
- readReg2  in  ADDR_W  read port 2 address
- readData1  out  DATA_W  read port 1 data (combinational)
- readData2  out  DATA_W  read port 2 data (combinational)
- wbPending  out  1  write-back register holds an uncommitted write
- wbData  out  DATA_W  value held in the write-back register

## Operation
- Register r0 is hardwired zero. Writes to r0 are discarded at capture, so wbPending does not rise. Reads of r0 return 0.
- **Capture (edge E):** with regWrite=1 and writeReg≠0, the stage loads the following and sets wbPending=1:
  - wb_addr = writeReg
  - wb_data = memToReg ? memData : aluResult
- **Capture (edge E), no write:** with regWrite=0 or writeReg=0, wbPending clears at E. wb_addr and wb_data hold their values.
- **Commit (edge E+1):** if wbPending=1 at E+1, then regs[wb_addr] ← wb_data.
- **Overlap:** capture and commit happen on the same edge with no stall. Full throughput is one write per cycle.
- **Read path:** for each port p, the result is chosen in this priority order:
  - readReg_p = 0 → 0
  - else wbPending and wb_addr == readReg_p → wb_data (bypass)
  - else regs[readReg_p]
- **Back-to-back writes to the same address:** the newer value is in wb_data while the older value commits. The bypass returns the newer value.
- No arithmetic is performed. The mux selects full DATA_W values without extension.

## Timing
- **Reset:** rst_n low asynchronously clears the following immediately, regardless of clk:
  - all regs
  - wbPending
  - wb_addr
  - wb_data
- **Outputs under reset:** readData1=readData2=0, wbPending=0, wbData=0.
- **Reset mid-operation:** a pending (uncommitted) write is lost. Registers already committed are also cleared.
- **Reset release:** the first capture occurs on the first rising edge with rst_n high.
- **Read latency:** readData reflects a captured write starting in the cycle after capture edge E, via the bypass. From E+1 on it comes from the array, and the value is identical in both cases.
- **Combinational path:** no path from regWrite, aluResult, memData or memToReg to readData. Only readReg → readData is combinational.
- **Simultaneous capture + commit, same address:** the array receives the older value and wb_data the newer value. Reads return the newer value.

## Test plan
- **Reset:** write r1=0x5A, commit, then pulse rst_n low between edges → readData1 on r1 = 0x00 immediately, wbPending=0.
- **Basic write:** regWrite=1, memToReg=0, writeReg=2, aluResult=0x3C, one edge → wbPending=1, wbData=0x3C, readData1 (readReg1=2) = 0x3C via bypass. After the next edge with regWrite=0 → wbPending=0, readData1 still 0x3C from the array.
- **Mux select:** memToReg=1, memData=0xA7, aluResult=0x11, writeReg=3 → r3 reads 0xA7, never 0x11.
- **r0 protection:** writeReg=0, aluResult=0xFF, regWrite=1 → wbPending=0, readData on r0 = 0x00.
- **Back-to-back same address:** consecutive cycles write r1=0x10 then r1=0x20 → after the second edge readData=0x20. After the third edge (idle) readData=0x20.
- **Reset mid-write:** capture r2=0x77, assert rst_n before the commit edge → after release r2 reads 0x00, wbPending=0.
